hyper_rd_fifo: RTL and testbench
================================

// Module: hyper_rd_fifo
// PURPOSE
//  Burst read-capture FIFO alongside the HyperRAM DWORD LocalBus bridge. Consumes the
//  rd_d/rd_rdy dword stream from the hyper interface during multi-dword reads and
//  buffers every dword; the bridge itself keeps only the last one. Software drains
//  the FIFO through a LocalBus data register and monitors/controls it via a status reg.
// PARAMETERS
//  DEPTH_LOG2  6  log2 of FIFO depth in dwords (default 64 >= max rd_num_dwords 63)
// PORTS
//  clk_lb      in   1   LocalBus/hyper clock; all logic on posedge
//  reset       in   1   synchronous, active-high reset
//  lb_cs_data  in   1   chip select, FIFO data register (read = pop)
//  lb_cs_stat  in   1   chip select, status/control register
//  lb_wr       in   1   LocalBus write strobe, 1 cycle
//  lb_rd       in   1   LocalBus read strobe, 1 cycle
//  lb_wr_d     in   32  LocalBus write data
//  lb_rd_d     out  32  LocalBus read data; 0 when lb_rd_rdy=0
//  lb_rd_rdy   out  1   read data valid, 1 cycle
//  rd_req      in   1   read-op start pulse (same pulse driven to the hyper interface)
//  rd_d        in   32  dword from the hyper interface
//  rd_rdy      in   1   rd_d valid, 1 cycle per dword
//  busy        in   1   hyper interface busy; reported in status
// BEHAVIOUR
//  Reset: wr_ptr=rd_ptr=count=0, overflow=underflow=0, auto_flush=1, lb_rd_d=0,
//   lb_rd_rdy=0. Storage array is not reset. count is DEPTH_LOG2+1 bits.
//  Push: rd_rdy=1 writes rd_d at wr_ptr; wr_ptr+1 (wraps mod 2^DEPTH_LOG2); count+1.
//   Full (count=2^DEPTH_LOG2) with no pop this cycle: dword dropped, overflow<=1.
//   Full with simultaneous pop: push accepted; count unchanged.
//  Pop: lb_rd & lb_cs_data -> next cycle lb_rd_rdy=1, lb_rd_d=mem[rd_ptr]; rd_ptr+1
//   (wraps); count-1. Empty: lb_rd_d=0, lb_rd_rdy=1, pointers unchanged, underflow<=1.
//   Push during an empty-pop is stored (no bypass); the pop still returns 0.
//  Simultaneous push+pop, non-empty, non-full: count unchanged, both pointers advance.
//  Status read: lb_rd & lb_cs_stat -> next cycle lb_rd_rdy=1, lb_rd_d =
//   [31]overflow [30]underflow [29]busy [28]full [27]empty [26]auto_flush
//   [15:0]count (zero-extended); other bits 0. Values sampled on the lb_rd cycle.
//  Control write: lb_wr & lb_cs_stat: bit0=1 flush (ptrs,count<=0); bit1=1 clear
//   overflow/underflow; bit2 loads auto_flush. Bits act in the same cycle.
//  Auto flush: rd_req=1 & auto_flush=1 -> flush, so each read op starts empty.
//  Flush beats push: a push in the flush cycle is discarded (no overflow set).
//   Flush beats pop: a pop in the flush cycle returns 0 and sets underflow.
//  Sticky-clear and a new overflow/underflow in the same cycle: flag ends set.
//  lb_cs_data and lb_cs_stat both high: data register wins; stat access ignored.
//  lb_wr & lb_cs_data: ignored (no push from LocalBus).
//  Reset mid-burst: all state returns to reset values next cycle; dwords arriving
//   during reset are dropped.
//  Read latency for both registers is exactly 1 cycle, matching the DWORD bridge.
// TESTING
//  Reset, status read -> 0x0C00_0000 (empty, auto_flush); data read -> 0, underflow.
//  Push 3 dwords 0x11,0x22,0x33, then 3 data reads -> 0x11,0x22,0x33; count 0, empty.
//  Push 65 dwords (DEPTH_LOG2=6) -> count=64, full=1, overflow=1; 64 pops return
//   dwords 1..64 in order; dword 65 lost.
//  Fill to 10, pulse rd_req -> count 0. Write ctrl 0x0 (auto_flush=0), fill 10,
//   pulse rd_req -> count stays 10.
//  Fill 64 (full), push+pop same cycle -> push accepted, count 64, overflow=0;
//   wrap: 200 streamed push/pop dwords return in order.
//  Push and ctrl-write 0x1 same cycle -> count 0, overflow 0. Write 0x2 after overflow
//   -> flags cleared. Assert reset mid-burst -> count 0, flags 0, lb_rd_rdy 0.

Source files
------------

// File: rtl/hyper_rd_fifo.sv
// Burst read-capture FIFO for the HyperRAM DWORD LocalBus bridge.
// Captures every rd_d dword that the hyper interface strobes with rd_rdy. Software
// drains the FIFO through a data register and monitors or controls it through a
// status/control register. Both registers answer a LocalBus read exactly one
// cycle later.
//
// Handshake: rd_rdy is a one-cycle valid with no backpressure. A dword that
// arrives while the FIFO is full and is not being popped is dropped, and the
// sticky overflow flag is set. A LocalBus read strobe (lb_rd) is always answered
// by a single lb_rd_rdy pulse on the next cycle. lb_rd_d is zero whenever
// lb_rd_rdy is low.
module hyper_rd_fifo #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic        clk_lb,
  input  logic        reset,
  input  logic        lb_cs_data,
  input  logic        lb_cs_stat,
  input  logic        lb_wr,
  input  logic        lb_rd,
  input  logic [31:0] lb_wr_d,
  output logic [31:0] lb_rd_d,
  output logic        lb_rd_rdy,
  input  logic        rd_req,
  input  logic [31:0] rd_d,
  input  logic        rd_rdy,
  input  logic        busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count, count_n;
  logic                  overflow, underflow, auto_flush;

  logic full, empty;
  logic data_rd, stat_acc, stat_rd, ctrl_wr;
  logic flush, sticky_clr;
  logic pop_ok, pop_under, push_ok, push_over;
  logic [31:0] status_word;
  logic unused_wr_d;

  // Only bits [2:0] of a control write carry meaning.
  assign unused_wr_d = ^lb_wr_d[31:3];

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // The data register wins when both chip selects are high, so the stat access is dropped.
  assign data_rd  = lb_rd & lb_cs_data;
  assign stat_acc = lb_cs_stat & ~lb_cs_data;
  assign stat_rd  = lb_rd & stat_acc;
  assign ctrl_wr  = lb_wr & stat_acc;

  // A flush overrides any push or pop in the same cycle.
  assign flush      = (ctrl_wr & lb_wr_d[0]) | (rd_req & auto_flush);
  assign sticky_clr = ctrl_wr & lb_wr_d[1];

  assign pop_ok    = data_rd & ~empty & ~flush;
  assign pop_under = data_rd & (empty | flush);
  // A full FIFO still accepts a dword when a pop frees a slot in the same cycle.
  assign push_ok   = rd_rdy & ~flush & (~full | pop_ok);
  assign push_over = rd_rdy & ~flush & full & ~pop_ok;

  assign status_word = {overflow, underflow, busy, full, empty, auto_flush, 10'b0,
                        {(16 - DEPTH_LOG2 - 1){1'b0}}, count};

  // Next occupancy: a push and a pop in the same cycle cancel out.
  always_comb begin
    count_n = count;
    if (push_ok && !pop_ok) begin
      count_n = count + CNT_ONE;
    end else if (!push_ok && pop_ok) begin
      count_n = count - CNT_ONE;
    end
  end

  // Dword storage. It has no reset, and dwords that arrive during reset are not written.
  always_ff @(posedge clk_lb) begin
    if (push_ok && !reset) begin
      mem[wr_ptr] <= rd_d;
    end
  end

  // Pointers, occupancy, sticky flags, auto-flush enable and the registered read port.
  always_ff @(posedge clk_lb) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      auto_flush <= 1'b1;
      lb_rd_d    <= '0;
      lb_rd_rdy  <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
        count <= count_n;
      end

      // A new event in the same cycle as a clear leaves the flag set.
      overflow  <= push_over | (overflow & ~sticky_clr);
      underflow <= pop_under | (underflow & ~sticky_clr);

      if (ctrl_wr) auto_flush <= lb_wr_d[2];

      lb_rd_rdy <= data_rd | stat_rd;
      if (pop_ok) begin
        lb_rd_d <= mem[rd_ptr];
      end else if (stat_rd) begin
        lb_rd_d <= status_word;
      end else begin
        lb_rd_d <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hyper_rd_fifo.sv
// Bench for hyper_rd_fifo. A queue-based reference model predicts every LocalBus
// read response from the FIFO rules: occupancy, sticky flags and flush behaviour.
module tb_hyper_rd_fifo;

  localparam int DEPTH = 64;

  logic        clk_lb = 1'b0;
  logic        reset;
  logic        lb_cs_data, lb_cs_stat, lb_wr, lb_rd;
  logic [31:0] lb_wr_d;
  logic [31:0] lb_rd_d;
  logic        lb_rd_rdy;
  logic        rd_req;
  logic [31:0] rd_d;
  logic        rd_rdy;
  logic        busy;

  // Clock and reset block
  always #5 clk_lb = ~clk_lb;

  hyper_rd_fifo #(.DEPTH_LOG2(6)) dut (
    .clk_lb     (clk_lb),
    .reset      (reset),
    .lb_cs_data (lb_cs_data),
    .lb_cs_stat (lb_cs_stat),
    .lb_wr      (lb_wr),
    .lb_rd      (lb_rd),
    .lb_wr_d    (lb_wr_d),
    .lb_rd_d    (lb_rd_d),
    .lb_rd_rdy  (lb_rd_rdy),
    .rd_req     (rd_req),
    .rd_d       (rd_d),
    .rd_rdy     (rd_rdy),
    .busy       (busy)
  );

  // Reference model state
  logic [31:0] exp_q[$];
  bit          m_ov, m_un, m_af;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status(input logic b);
    logic [31:0] s;
    s        = '0;
    s[31]    = m_ov;
    s[30]    = m_un;
    s[29]    = b;
    s[28]    = (exp_q.size() == DEPTH);
    s[27]    = (exp_q.size() == 0);
    s[26]    = m_af;
    s[15:0]  = 16'(exp_q.size());
    return s;
  endfunction

  task automatic idle();
    lb_cs_data = 1'b0; lb_cs_stat = 1'b0; lb_wr = 1'b0; lb_rd = 1'b0;
    lb_wr_d = '0; rd_req = 1'b0; rd_rdy = 1'b0; rd_d = '0; busy = 1'b0;
  endtask

  // One clock of stimulus: update the model, drive the DUT, then check the read port.
  task automatic step(input string tag, input logic cs_d, input logic cs_s,
                      input logic wr, input logic rd, input logic [31:0] wd,
                      input logic req, input logic rdy, input logic [31:0] d,
                      input logic b);
    logic [31:0] exp_d;
    logic        exp_rdy, stat_acc, ctrl, fl, ov_ev, un_ev;
    exp_d = '0; exp_rdy = 1'b0; ov_ev = 1'b0; un_ev = 1'b0;
    stat_acc = cs_s & ~cs_d;
    ctrl     = wr & stat_acc;
    fl       = (ctrl & wd[0]) | (req & m_af);
    if (rd && stat_acc) begin
      exp_rdy = 1'b1;
      exp_d   = m_status(b);
    end
    if (rd && cs_d) begin
      exp_rdy = 1'b1;
      if (!fl && exp_q.size() > 0) exp_d = exp_q.pop_front();
      else un_ev = 1'b1;
    end
    if (fl) exp_q.delete();
    if (rdy && !fl) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else ov_ev = 1'b1;
    end
    if (ctrl && wd[1]) begin m_ov = 1'b0; m_un = 1'b0; end
    if (ov_ev) m_ov = 1'b1;
    if (un_ev) m_un = 1'b1;
    if (ctrl) m_af = wd[2];

    lb_cs_data = cs_d; lb_cs_stat = cs_s; lb_wr = wr; lb_rd = rd; lb_wr_d = wd;
    rd_req = req; rd_rdy = rdy; rd_d = d; busy = b;
    @(posedge clk_lb); #1;
    chk({tag, ".rdy"}, {31'b0, lb_rd_rdy}, {31'b0, exp_rdy});
    chk({tag, ".d"}, lb_rd_d, exp_d);
    idle();
  endtask

  // Driver tasks
  task automatic push(input logic [31:0] d);
    step("push", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, d, 1'b0);
  endtask
  task automatic pop(input string tag);
    step(tag, 1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask
  task automatic stat(input string tag);
    step(tag, 1'b0, 1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask
  task automatic ctrl(input string tag, input logic [31:0] w);
    step(tag, 1'b0, 1'b1, 1'b1, 1'b0, w, 1'b0, 1'b0, '0, 1'b0);
  endtask
  task automatic req_pulse(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
  endtask

  // Reset with dwords streaming in; none of them may be captured.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      reset = 1'b1; rd_rdy = 1'b1; rd_d = $urandom;
      @(posedge clk_lb); #1;
    end
    reset = 1'b0;
    idle();
    exp_q.delete(); m_ov = 1'b0; m_un = 1'b0; m_af = 1'b1;
    chk("reset.rdy", {31'b0, lb_rd_rdy}, 32'h0);
    chk("reset.d", lb_rd_d, 32'h0);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    do_reset(3);

    // Reset state: expect status 0x0C00_0000, and an empty pop returning 0 with underflow set.
    stat("rst_stat");
    chk("rst_stat_const", lb_rd_d, 32'h0C00_0000);
    pop("empty_pop");
    stat("under_stat");

    // Basic ordering
    ctrl("clr", 32'h6);
    push(32'h11); push(32'h22); push(32'h33);
    pop("pop11"); pop("pop22"); pop("pop33");
    stat("basic_stat");

    // Overflow: 65 pushes into 64 entries
    for (int i = 1; i <= 65; i++) push(32'(i));
    stat("full_stat");
    for (int i = 0; i < 64; i++) pop("drain");
    pop("drain_empty");
    stat("drain_stat");

    // Auto flush on rd_req, then with auto flush disabled
    ctrl("clr2", 32'h6);
    for (int i = 0; i < 10; i++) push($urandom);
    req_pulse("req_af1");
    stat("af1_stat");
    ctrl("af_off", 32'h0);
    for (int i = 0; i < 10; i++) push($urandom);
    req_pulse("req_af0");
    stat("af0_stat");

    // Full with simultaneous push+pop, then a long wrapping stream
    ctrl("flush_clr", 32'h3);
    for (int i = 0; i < 64; i++) push($urandom);
    step("full_pushpop", 1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b1, $urandom, 1'b0);
    stat("full_pp_stat");
    for (int i = 0; i < 200; i++)
      step("stream", 1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b1, $urandom, 1'b0);
    for (int i = 0; i < 64; i++) pop("stream_drain");
    stat("stream_stat");

    // A flush wins over a push in the same cycle
    push(32'hAB);
    step("push_flush", 1'b0, 1'b1, 1'b1, 1'b0, 32'h1, 1'b0, 1'b1, 32'hCD, 1'b0);
    stat("push_flush_stat");

    // Sticky clear after an overflow
    for (int i = 0; i < 65; i++) push($urandom);
    stat("ovf_stat");
    ctrl("clr_ovf", 32'h2);
    stat("clr_ovf_stat");

    // Randomized mixed traffic
    ctrl("rand_init", 32'h7);
    for (int i = 0; i < 600; i++) begin
      logic       cs_d, cs_s, wr, rd, req, rdy, b;
      logic [31:0] wd;
      cs_d = ($urandom_range(0, 2) == 0);
      cs_s = ($urandom_range(0, 3) == 0);
      rd   = ($urandom_range(0, 1) == 0);
      wr   = ($urandom_range(0, 9) == 0);
      wd   = 32'($urandom_range(0, 7)) | ($urandom & 32'hFFFF_FFF8);
      req  = ($urandom_range(0, 31) == 0);
      rdy  = ($urandom_range(0, 2) != 0);
      b    = ($urandom_range(0, 1) == 0);
      step("rand", cs_d, cs_s, wr, rd, wd, req, rdy, $urandom, b);
    end
    stat("rand_stat");

    // Reset asserted in the middle of a burst
    for (int i = 0; i < 5; i++) push($urandom);
    do_reset(2);
    stat("post_rst_stat");
    chk("post_rst_const", lb_rd_d, 32'h0C00_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
